// File: rtl/lock_pkg.sv
// Shared definitions for the multi-door lock controller: channel state
// encoding and default timing parameters.
package lock_pkg;

    typedef enum logic {
        LOCKED   = 1'b0,
        UNLOCKED = 1'b1
    } lock_state_t;

    localparam int DEFAULT_RELOCK_CYCLES = 25;
    localparam int DEFAULT_CNT_W         = 16;

endpackage

// File: rtl/lock_channel.sv
// One door channel: LOCKED/UNLOCKED state with an auto-relock timer.
// The registered state is the observable debug view of the FSM.
module lock_channel
    import lock_pkg::*;
#(
    parameter int RELOCK_CYCLES = DEFAULT_RELOCK_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W,
    parameter int AUTO_RELOCK   = 1
) (
    input  logic        clk5,
    input  logic        reset,
    input  logic        toggle,
    input  logic        force_lock,
    output lock_state_t state,
    output logic        relock_evt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RELOCK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             timeout;

    assign timeout = (AUTO_RELOCK != 0) && (cnt == LAST_CNT);

    always_ff @(posedge clk5 or negedge reset) begin
        if (!reset) begin
            state      <= LOCKED;
            cnt        <= '0;
            relock_evt <= 1'b0;
        end else begin
            relock_evt <= 1'b0;
            if (force_lock) begin
                state <= LOCKED;
                cnt   <= '0;
            end else begin
                case (state)
                    LOCKED: begin
                        if (toggle) begin
                            state <= UNLOCKED;
                            cnt   <= '0;
                        end
                    end
                    UNLOCKED: begin
                        // A manual toggle wins over a simultaneous timeout, so no event.
                        if (toggle) begin
                            state <= LOCKED;
                            cnt   <= '0;
                        end else if (timeout) begin
                            state      <= LOCKED;
                            cnt        <= '0;
                            relock_evt <= 1'b1;
                        end else if (AUTO_RELOCK != 0) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= LOCKED;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/multi_lock_ctrl.sv
// Multi-door lock controller: N_DOORS independent lock channels sharing the
// keypad override and the emergency force_lock.
module multi_lock_ctrl
    import lock_pkg::*;
#(
    parameter int N_DOORS       = 2,
    parameter int RELOCK_CYCLES = DEFAULT_RELOCK_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W,
    parameter int AUTO_RELOCK   = 1
) (
    input  logic               clk5,
    input  logic               reset,
    input  logic [N_DOORS-1:0] CleanPB,
    input  logic [N_DOORS-1:0] ToggleLock,
    input  logic               override,
    input  logic               force_lock,
    output logic [N_DOORS-1:0] unlock,
    output logic [N_DOORS-1:0] relock_evt,
    output logic               any_unlocked
);

    lock_state_t chan_state [N_DOORS];

    genvar i;
    generate
        for (i = 0; i < N_DOORS; i++) begin : g_chan
            logic toggle;

            // Button and keypad are OR-ed, so both at once still toggle only once.
            assign toggle = CleanPB[i] | (ToggleLock[i] & ~override);

            lock_channel #(
                .RELOCK_CYCLES(RELOCK_CYCLES),
                .CNT_W        (CNT_W),
                .AUTO_RELOCK  (AUTO_RELOCK)
            ) u_chan (
                .clk5      (clk5),
                .reset     (reset),
                .toggle    (toggle),
                .force_lock(force_lock),
                .state     (chan_state[i]),
                .relock_evt(relock_evt[i])
            );

            assign unlock[i] = (chan_state[i] == UNLOCKED);
        end
    endgenerate

    assign any_unlocked = |unlock;

endmodule

// File: tb/tb_multi_lock_ctrl.sv
// Directed self-checking bench for multi_lock_ctrl (2 doors, 10-cycle relock),
// plus a second instance with auto-relock disabled.
module tb_multi_lock_ctrl;

    logic       clk5;
    logic       reset;
    logic [1:0] CleanPB;
    logic [1:0] ToggleLock;
    logic       override;
    logic       force_lock;
    logic [1:0] unlock;
    logic [1:0] relock_evt;
    logic       any_unlocked;

    logic [1:0] clean_pb_b;
    logic [1:0] toggle_lock_b;
    logic [1:0] unlock_b;
    logic [1:0] relock_evt_b;
    logic       any_unlocked_b;

    int tests_run;
    int tests_failed;

    // clock / reset
    initial clk5 = 1'b0;
    always #5 clk5 = ~clk5;

    multi_lock_ctrl #(
        .N_DOORS      (2),
        .RELOCK_CYCLES(10),
        .CNT_W        (16),
        .AUTO_RELOCK  (1)
    ) dut (
        .clk5        (clk5),
        .reset       (reset),
        .CleanPB     (CleanPB),
        .ToggleLock  (ToggleLock),
        .override    (override),
        .force_lock  (force_lock),
        .unlock      (unlock),
        .relock_evt  (relock_evt),
        .any_unlocked(any_unlocked)
    );

    multi_lock_ctrl #(
        .N_DOORS      (2),
        .RELOCK_CYCLES(10),
        .CNT_W        (16),
        .AUTO_RELOCK  (0)
    ) dut_nar (
        .clk5        (clk5),
        .reset       (reset),
        .CleanPB     (clean_pb_b),
        .ToggleLock  (toggle_lock_b),
        .override    (override),
        .force_lock  (force_lock),
        .unlock      (unlock_b),
        .relock_evt  (relock_evt_b),
        .any_unlocked(any_unlocked_b)
    );

    // driver: advance one edge, then settle before sampling
    task automatic step();
        @(posedge clk5);
        #1;
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if (unlock !== 2'b00 || relock_evt !== 2'b00 || any_unlocked !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: unlock=%b relock_evt=%b any=%b, required 00/00/0",
                     unlock, relock_evt, any_unlocked);
        end
        tests_run++;
        if (unlock_b !== 2'b00 || relock_evt_b !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_state_nar: unlock=%b relock_evt=%b, required 00/00",
                     unlock_b, relock_evt_b);
        end
    endtask

    task automatic test_first_edge();
        CleanPB = 2'b01;
        @(negedge clk5);
        reset = 1'b1;
        step();
        CleanPB = 2'b00;
        tests_run++;
        if (unlock !== 2'b01) begin
            tests_failed++;
            $display("FAIL first_edge: unlock=%b, required 01", unlock);
        end
        CleanPB = 2'b01;
        step();
        CleanPB = 2'b00;
        tests_run++;
        if (unlock !== 2'b00 || relock_evt !== 2'b00) begin
            tests_failed++;
            $display("FAIL manual_lock: unlock=%b relock_evt=%b, required 00/00", unlock, relock_evt);
        end
    endtask

    task automatic test_auto_relock();
        CleanPB = 2'b01;
        step();
        CleanPB = 2'b00;
        tests_run++;
        if (unlock !== 2'b01 || any_unlocked !== 1'b1) begin
            tests_failed++;
            $display("FAIL relock_open: unlock=%b any=%b, required 01/1", unlock, any_unlocked);
        end
        for (int k = 1; k <= 9; k++) begin
            step();
            tests_run++;
            if (unlock !== 2'b01 || relock_evt !== 2'b00) begin
                tests_failed++;
                $display("FAIL relock_hold[%0d]: unlock=%b relock_evt=%b, required 01/00",
                         k, unlock, relock_evt);
            end
        end
        step();
        tests_run++;
        if (unlock !== 2'b00 || relock_evt !== 2'b01) begin
            tests_failed++;
            $display("FAIL relock_expire: unlock=%b relock_evt=%b, required 00/01", unlock, relock_evt);
        end
        step();
        tests_run++;
        if (unlock !== 2'b00 || relock_evt !== 2'b00) begin
            tests_failed++;
            $display("FAIL relock_pulse_end: unlock=%b relock_evt=%b, required 00/00", unlock, relock_evt);
        end
    endtask

    task automatic test_override();
        override   = 1'b1;
        ToggleLock = 2'b11;
        step();
        tests_run++;
        if (unlock !== 2'b00 || any_unlocked !== 1'b0) begin
            tests_failed++;
            $display("FAIL override_mask: unlock=%b any=%b, required 00/0", unlock, any_unlocked);
        end
        override = 1'b0;
        step();
        ToggleLock = 2'b00;
        tests_run++;
        if (unlock !== 2'b11 || any_unlocked !== 1'b1) begin
            tests_failed++;
            $display("FAIL keypad_open: unlock=%b any=%b, required 11/1", unlock, any_unlocked);
        end
        CleanPB = 2'b11;
        step();
        CleanPB = 2'b00;
        tests_run++;
        if (unlock !== 2'b00 || relock_evt !== 2'b00) begin
            tests_failed++;
            $display("FAIL button_lock_both: unlock=%b relock_evt=%b, required 00/00", unlock, relock_evt);
        end
    endtask

    task automatic test_toggle_at_expiry();
        CleanPB = 2'b10;
        step();
        CleanPB = 2'b00;
        tests_run++;
        if (unlock !== 2'b10) begin
            tests_failed++;
            $display("FAIL door1_open: unlock=%b, required 10", unlock);
        end
        repeat (9) step();
        tests_run++;
        if (unlock !== 2'b10) begin
            tests_failed++;
            $display("FAIL door1_last_cycle: unlock=%b, required 10", unlock);
        end
        CleanPB = 2'b10;
        step();
        CleanPB = 2'b00;
        tests_run++;
        if (unlock !== 2'b00 || relock_evt !== 2'b00) begin
            tests_failed++;
            $display("FAIL toggle_at_expiry: unlock=%b relock_evt=%b, required 00/00", unlock, relock_evt);
        end
        step();
        tests_run++;
        if (unlock !== 2'b00 || relock_evt !== 2'b00) begin
            tests_failed++;
            $display("FAIL toggle_at_expiry_after: unlock=%b relock_evt=%b, required 00/00",
                     unlock, relock_evt);
        end
    endtask

    task automatic test_both_sources();
        CleanPB    = 2'b01;
        ToggleLock = 2'b01;
        step();
        CleanPB    = 2'b00;
        ToggleLock = 2'b00;
        tests_run++;
        if (unlock !== 2'b01) begin
            tests_failed++;
            $display("FAIL single_toggle: unlock=%b, required 01", unlock);
        end
        step();
        tests_run++;
        if (unlock !== 2'b01) begin
            tests_failed++;
            $display("FAIL single_toggle_hold: unlock=%b, required 01", unlock);
        end
        CleanPB = 2'b01;
        step();
        CleanPB = 2'b00;
        tests_run++;
        if (unlock !== 2'b00) begin
            tests_failed++;
            $display("FAIL single_toggle_lock: unlock=%b, required 00", unlock);
        end
    endtask

    task automatic test_force_lock();
        CleanPB = 2'b11;
        step();
        CleanPB = 2'b00;
        tests_run++;
        if (unlock !== 2'b11) begin
            tests_failed++;
            $display("FAIL force_setup: unlock=%b, required 11", unlock);
        end
        force_lock = 1'b1;
        for (int k = 0; k < 3; k++) begin
            CleanPB = (k == 1) ? 2'b00 : 2'b11;
            step();
            tests_run++;
            if (unlock !== 2'b00 || relock_evt !== 2'b00) begin
                tests_failed++;
                $display("FAIL force_hold[%0d]: unlock=%b relock_evt=%b, required 00/00",
                         k, unlock, relock_evt);
            end
        end
        force_lock = 1'b0;
        CleanPB    = 2'b00;
        repeat (3) step();
        tests_run++;
        if (unlock !== 2'b00 || relock_evt !== 2'b00) begin
            tests_failed++;
            $display("FAIL force_release: unlock=%b relock_evt=%b, required 00/00", unlock, relock_evt);
        end
    endtask

    task automatic test_reset_mid();
        CleanPB = 2'b11;
        step();
        CleanPB = 2'b00;
        repeat (4) step();
        tests_run++;
        if (unlock !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_mid_setup: unlock=%b, required 11", unlock);
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (unlock !== 2'b00 || any_unlocked !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: unlock=%b any=%b, required 00/0", unlock, any_unlocked);
        end
        @(negedge clk5);
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            tests_run++;
            if (unlock !== 2'b00 || relock_evt !== 2'b00) begin
                tests_failed++;
                $display("FAIL reset_aborts_timer[%0d]: unlock=%b relock_evt=%b, required 00/00",
                         k, unlock, relock_evt);
            end
        end
    endtask

    task automatic test_no_auto_relock();
        clean_pb_b = 2'b01;
        step();
        clean_pb_b = 2'b00;
        tests_run++;
        if (unlock_b !== 2'b01 || any_unlocked_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL nar_open: unlock=%b any=%b, required 01/1", unlock_b, any_unlocked_b);
        end
        for (int k = 0; k < 30; k++) begin
            step();
            tests_run++;
            if (unlock_b !== 2'b01 || relock_evt_b !== 2'b00) begin
                tests_failed++;
                $display("FAIL nar_stays_open[%0d]: unlock=%b relock_evt=%b, required 01/00",
                         k, unlock_b, relock_evt_b);
            end
        end
        clean_pb_b = 2'b01;
        step();
        clean_pb_b = 2'b00;
        tests_run++;
        if (unlock_b !== 2'b00 || relock_evt_b !== 2'b00) begin
            tests_failed++;
            $display("FAIL nar_manual_lock: unlock=%b relock_evt=%b, required 00/00",
                     unlock_b, relock_evt_b);
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset         = 1'b0;
        CleanPB       = 2'b00;
        ToggleLock    = 2'b00;
        override      = 1'b0;
        force_lock    = 1'b0;
        clean_pb_b    = 2'b00;
        toggle_lock_b = 2'b00;

        test_reset();
        test_first_edge();
        test_auto_relock();
        test_override();
        test_toggle_at_expiry();
        test_both_sources();
        test_force_lock();
        test_reset_mid();
        test_no_auto_relock();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
